// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: feeds one external full-adder cell LSB-first and assembles the result.
// Optional subtract mode (sub port) is enabled with `define SERIAL_ADD_SUB_EN.
//
// state  | meaning
// IDLE   | waiting for start, result registers hold the last result
// RUN    | one operand bit pair per clock through the full adder
// DONE   | one-cycle result-valid pulse; start here chains the next operation
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_carry;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  // The shared cell sees zeros whenever it is not ours to use.
  assign fa_a = busy & a_q[0];
  assign fa_b = busy & b_q[0];
  assign fa_c = busy & carry_q;

endmodule
